conv_weight_fetch_ctrl: RTL and testbench
=========================================

Name: conv_weight_fetch_ctrl

Overview:
- Sequences per-filter weight reads from a conv-layer weight ROM. The ROM is single-port and wide: one address returns all WORDS_PER_FILTER weights of one output filter, concatenated.
- Issues the ROM enable and filter address, waits the ROM read latency, and registers the concatenated weight vector.
- Hands each filter's weights to the downstream PE array over a valid/ready handshake.
- Sits between the layer-level control FSM and the conv PE array; one instance per conv layer.

Parameters:
- NUM_FILTERS, 8, number of output filters (ROM depth) fetched per layer run; legal range ≥1.
- WORDS_PER_FILTER, 36, weights per filter (3x3 kernel x 4 input channels).
- DATA_WIDTH, 16, bits per weight, fixed-point.
- ROM_LATENCY, 1, cycles from the edge that samples rom_en to rom_data valid; legal range 1..4.
- IDX_W, $clog2(NUM_FILTERS) (min 1), width of the filter index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a layer run when the block is idle.
- abort  in  1  synchronous cancel of the current run.
- busy  out  1  high from the cycle after start is accepted until the run finishes.
- done  out  1  one-cycle pulse after the last filter's handshake.
- rom_en  out  1  ROM read enable, one-cycle pulse per filter.
- rom_addr  out  IDX_W  filter index presented with rom_en.
- rom_data  in  WORDS_PER_FILTER*DATA_WIDTH  ROM read data; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- w_valid  out  1  w_data/w_filter_idx hold a valid filter.
- w_ready  in  1  downstream accepts the filter.
- w_data  out  WORDS_PER_FILTER*DATA_WIDTH  registered weight vector, same packing as rom_data.
- w_filter_idx  out  IDX_W  index of the filter currently on w_data.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - busy, done, rom_en, w_valid = 0.
  - rom_addr, w_data, w_filter_idx, idx, lat_cnt = 0.
  - rst has priority over all other inputs.
- FSM states and transitions:
  - IDLE: start=1 → FETCH; idx←0; busy←1. start while not IDLE is ignored.
  - FETCH: one cycle. rom_en=1, rom_addr=idx. Then → WAIT with lat_cnt←0.
  - WAIT: lat_cnt increments each cycle. When lat_cnt==ROM_LATENCY-1: capture w_data←rom_data, w_filter_idx←idx, w_valid←1, → HOLD.
  - HOLD: w_valid=1; w_data and w_filter_idx are stable until the handshake.
    - Handshake = w_valid & w_ready at an edge; clears w_valid.
    - If idx==NUM_FILTERS-1 → DONE.
    - Otherwise idx←idx+1 → FETCH.
  - DONE: done=1 for exactly one cycle; busy←0; → IDLE.
- Timing, with start sampled at edge T0:
  - rom_en is high for cycle T0..T1.
  - w_valid rises at edge T1+ROM_LATENCY (T2 for the default).
  - After a handshake at edge Th, the next rom_en is sampled at Th+1 and w_valid rises again at Th+1+ROM_LATENCY.
  - Minimum period per filter: 2+ROM_LATENCY cycles (3 for the default).
- Back-pressure: w_ready may be held low indefinitely. w_valid stays high, w_data is unchanged, and no new rom_en is issued.
- Combinational paths: w_ready has no combinational path to any output.
- rom_en is never high outside FETCH. rom_addr holds its last value outside FETCH.
- rom_data is only sampled in the WAIT capture cycle; the value at other times is don't-care.
- abort:
  - abort=1 in any state other than IDLE → IDLE next edge: w_valid←0, busy←0, no done pulse, idx←0.
  - abort has priority over start and over a same-cycle handshake; that filter counts as not transferred.
  - abort in IDLE has no effect.
  - start and abort together in IDLE: abort wins and the block stays IDLE.
- done and a new start: start is ignored in the DONE cycle and accepted from the following IDLE cycle onward.
- NUM_FILTERS=1: FETCH→WAIT→HOLD→DONE with idx staying 0. idx never wraps within a run.
- Reset mid-run (any state) follows the reset rule above. Any in-flight ROM response is discarded because state is IDLE.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release with no start → all outputs 0 for 10 cycles; rom_en never asserts.
- Full run, no back-pressure (NUM_FILTERS=8, ROM_LATENCY=1, w_ready=1, ROM word k of filter f = f*256+k) → 8 transfers with w_filter_idx 0..7 and matching w_data.
  - w_valid first rises 2 cycles after start; transfers are spaced 3 cycles apart.
  - done pulses once, 1 cycle after the idx=7 handshake; busy is high for exactly 8*3+1 cycles.
- Back-pressure: hold w_ready=0 for 20 cycles on filter 3 → w_valid stays high, w_data/w_filter_idx=3 are stable, no rom_en. On release, filter 4's rom_en follows 1 cycle after the handshake.
- Latency sweep: ROM_LATENCY=3 with a ROM model of matching latency → w_valid rises 4 cycles after start; data matches; the per-filter period is 5 cycles.
- Abort mid-HOLD, with w_ready=1 in the same cycle (filter 5) → next cycle busy=0 and w_valid=0; done never pulses. A new start refetches from filter 0.
- Ignored start: pulse start during HOLD of filter 2 and again in the DONE cycle → run unaffected, no second run begins. A start one cycle later begins a new run.

Source files
------------

// File: rtl/conv_weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// conv_weight_fetch_ctrl
//
// Purpose:
//   Fetches the weights of one conv layer, one output filter at a time, from a
//   wide single-port weight ROM. Each ROM address holds every weight of one
//   filter, concatenated. For each filter the block pulses the ROM enable with
//   the filter address, waits out the ROM read latency, and registers the
//   weight vector. It then offers the vector to the PE array over a
//   valid/ready handshake. A layer run covers filters 0..NUM_FILTERS-1 and
//   ends with a one-cycle done pulse.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset, highest priority
//   start         pulse; begins a layer run when idle
//   abort         synchronous cancel of the current run (no done pulse)
//   busy          high from the cycle after start is accepted until run end
//   done          one-cycle pulse after the last filter's handshake
//   rom_en        ROM read enable, one-cycle pulse per filter
//   rom_addr      filter index presented with rom_en (holds otherwise)
//   rom_data      ROM read data, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   w_valid       w_data / w_filter_idx hold a valid filter
//   w_ready       downstream accepts the filter
//   w_data        registered weight vector, same packing as rom_data
//   w_filter_idx  index of the filter currently on w_data
//
// All outputs are registers, so w_ready has no combinational path to any of
// them.
// -----------------------------------------------------------------------------
module conv_weight_fetch_ctrl #(
    parameter int NUM_FILTERS      = 8,
    parameter int WORDS_PER_FILTER = 36,
    parameter int DATA_WIDTH       = 16,
    parameter int ROM_LATENCY      = 1,
    parameter int IDX_W            = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   rom_en,
    output logic [IDX_W-1:0]                       rom_addr,
    input  logic [WORDS_PER_FILTER*DATA_WIDTH-1:0] rom_data,
    output logic                                   w_valid,
    input  logic                                   w_ready,
    output logic [WORDS_PER_FILTER*DATA_WIDTH-1:0] w_data,
    output logic [IDX_W-1:0]                       w_filter_idx
);

    localparam int VEC_W = WORDS_PER_FILTER * DATA_WIDTH;
    localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              rom_en_q;
    logic              w_valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  rom_addr_q;
    logic [IDX_W-1:0]  w_filter_idx_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [VEC_W-1:0]  w_data_q;

    logic [IDX_W-1:0]  idx_d;
    logic [LAT_W-1:0]  lat_cnt_d;
    logic              hs_d;

    assign idx_d     = idx_q + IDX_W'(1);
    assign lat_cnt_d = lat_cnt_q + LAT_W'(1);
    assign hs_d      = w_valid_q & w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rom_en_q       <= 1'b0;
            w_valid_q      <= 1'b0;
            idx_q          <= '0;
            rom_addr_q     <= '0;
            w_filter_idx_q <= '0;
            lat_cnt_q      <= '0;
            w_data_q       <= '0;
        end else if (abort && (state_q != S_IDLE)) begin
            // Cancel beats a same-cycle handshake: the filter on w_data is
            // dropped, and w_data / w_filter_idx / rom_addr simply hold.
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rom_en_q  <= 1'b0;
            w_valid_q <= 1'b0;
            idx_q     <= '0;
            lat_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort held together with start keeps the block idle.
                    if (start && !abort) begin
                        state_q    <= S_FETCH;
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= '0;
                    end
                end

                S_FETCH: begin
                    // rom_en was raised on entry, so it spans exactly this cycle.
                    rom_en_q  <= 1'b0;
                    lat_cnt_q <= '0;
                    state_q   <= S_WAIT;
                end

                S_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        w_data_q       <= rom_data;
                        w_filter_idx_q <= idx_q;
                        w_valid_q      <= 1'b1;
                        state_q        <= S_HOLD;
                    end else begin
                        lat_cnt_q <= lat_cnt_d;
                    end
                end

                S_HOLD: begin
                    if (hs_d) begin
                        w_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            // Go straight to the next fetch so that rom_en is
                            // high in the cycle right after the handshake.
                            idx_q      <= idx_d;
                            rom_addr_q <= idx_d;
                            rom_en_q   <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    // A start seen in this cycle is ignored.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    rom_en_q  <= 1'b0;
                    w_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rom_en       = rom_en_q;
    assign rom_addr     = rom_addr_q;
    assign w_valid      = w_valid_q;
    assign w_data       = w_data_q;
    assign w_filter_idx = w_filter_idx_q;

endmodule

// File: tb/tb_conv_weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for conv_weight_fetch_ctrl. Two instances share one set of
// control inputs: one with ROM latency 1 and one with ROM latency 3. Each
// instance has its own ROM model of matching latency. A transaction-level
// timing model predicts every output of both instances on every cycle.
// -----------------------------------------------------------------------------
module tb_conv_weight_fetch_ctrl;

    localparam int NF  = 8;
    localparam int WPF = 36;
    localparam int DW  = 16;
    localparam int VW  = WPF * DW;
    localparam int IW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, w_ready;
    logic          busy0, done0, rom_en0, w_valid0;
    logic          busy1, done1, rom_en1, w_valid1;
    logic [IW-1:0] rom_addr0, fidx0, rom_addr1, fidx1;
    logic [VW-1:0] rom_data0, w_data0, rom_data1, w_data1;

    conv_weight_fetch_ctrl #(.NUM_FILTERS(NF), .WORDS_PER_FILTER(WPF),
                             .DATA_WIDTH(DW), .ROM_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy0), .done(done0), .rom_en(rom_en0), .rom_addr(rom_addr0),
        .rom_data(rom_data0), .w_valid(w_valid0), .w_ready(w_ready),
        .w_data(w_data0), .w_filter_idx(fidx0));

    conv_weight_fetch_ctrl #(.NUM_FILTERS(NF), .WORDS_PER_FILTER(WPF),
                             .DATA_WIDTH(DW), .ROM_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy1), .done(done1), .rom_en(rom_en1), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .w_valid(w_valid1), .w_ready(w_ready),
        .w_data(w_data1), .w_filter_idx(fidx1));

    // ROM content: word k of filter f = f*256 + k
    function automatic logic [VW-1:0] rom_word(int f);
        logic [VW-1:0] w;
        for (int k = 0; k < WPF; k++) w[k*DW +: DW] = DW'(f * 256 + k);
        return w;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < VW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    // ROM models: garbage whenever the enable was not sampled, so a capture
    // at the wrong moment is visible.
    logic [VW-1:0] rom0_q;
    logic [VW-1:0] rom1_p [3];
    always @(posedge clk) begin
        rom0_q    <= rom_en0 ? rom_word(int'(rom_addr0)) : rnd_vec();
        rom1_p[0] <= rom_en1 ? rom_word(int'(rom_addr1)) : rnd_vec();
        rom1_p[1] <= rom1_p[0];
        rom1_p[2] <= rom1_p[1];
    end
    assign rom_data0 = rom0_q;
    assign rom_data1 = rom1_p[2];

    // ---------------- reference model ----------------
    int            errors = 0;
    int            checks = 0;
    int            edge_n = 0;
    int            lat_of [2] = '{1, 3};
    bit            m_busy [2], m_done [2], m_romen [2], m_vld [2];
    int            m_idx [2], m_addr [2], m_fidx [2], m_cap [2];
    logic [VW-1:0] m_data [2];

    int busy_cnt0, done_cnt0, hs_cnt0, busy_cnt1, done_cnt1, hs_cnt1;

    task automatic model_step(bit r, bit s, bit a, bit rdy);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_busy[i] = 0; m_done[i] = 0; m_romen[i] = 0; m_vld[i] = 0;
                m_idx[i] = 0; m_addr[i] = 0; m_fidx[i] = 0; m_cap[i] = -1;
                m_data[i] = '0;
            end else if (m_busy[i] && a) begin
                m_busy[i] = 0; m_done[i] = 0; m_romen[i] = 0; m_vld[i] = 0;
                m_idx[i] = 0; m_cap[i] = -1;
            end else if (m_done[i]) begin
                m_done[i] = 0; m_busy[i] = 0;
            end else if (!m_busy[i]) begin
                if (s && !a) begin
                    m_busy[i] = 1; m_idx[i] = 0; m_romen[i] = 1; m_addr[i] = 0;
                    m_cap[i] = edge_n + 1 + lat_of[i];
                end
            end else begin
                m_romen[i] = 0;
                if (m_vld[i] && rdy) begin
                    m_vld[i] = 0;
                    if (m_idx[i] == NF - 1) m_done[i] = 1;
                    else begin
                        m_idx[i]++;
                        m_romen[i] = 1;
                        m_addr[i] = m_idx[i];
                        m_cap[i] = edge_n + 1 + lat_of[i];
                    end
                end else if (!m_vld[i] && edge_n == m_cap[i]) begin
                    m_vld[i] = 1; m_fidx[i] = m_idx[i]; m_data[i] = rom_word(m_idx[i]);
                end
            end
        end
    endtask

    task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic check_dut(int i, logic b, logic d, logic re, logic v,
                             logic [IW-1:0] ad, logic [IW-1:0] fi, logic [VW-1:0] wd);
        chk($sformatf("dut%0d.busy", i), VW'(b), VW'(m_busy[i]));
        chk($sformatf("dut%0d.done", i), VW'(d), VW'(m_done[i]));
        chk($sformatf("dut%0d.rom_en", i), VW'(re), VW'(m_romen[i]));
        chk($sformatf("dut%0d.w_valid", i), VW'(v), VW'(m_vld[i]));
        chk($sformatf("dut%0d.rom_addr", i), VW'(ad), VW'(m_addr[i]));
        chk($sformatf("dut%0d.w_filter_idx", i), VW'(fi), VW'(m_fidx[i]));
        chk($sformatf("dut%0d.w_data", i), wd, m_data[i]);
    endtask

    task automatic cyc(bit r, bit s, bit a, bit rdy);
        bit hs0, hs1;
        rst = r; start = s; abort = a; w_ready = rdy;
        hs0 = (w_valid0 === 1'b1) && rdy && !r && !a;
        hs1 = (w_valid1 === 1'b1) && rdy && !r && !a;
        @(posedge clk); #1;
        model_step(r, s, a, rdy);
        check_dut(0, busy0, done0, rom_en0, w_valid0, rom_addr0, fidx0, w_data0);
        check_dut(1, busy1, done1, rom_en1, w_valid1, rom_addr1, fidx1, w_data1);
        hs_cnt0 += int'(hs0); hs_cnt1 += int'(hs1);
        busy_cnt0 += int'(busy0 === 1'b1); busy_cnt1 += int'(busy1 === 1'b1);
        done_cnt0 += int'(done0 === 1'b1); done_cnt1 += int'(done1 === 1'b1);
    endtask

    task automatic clear_counts();
        busy_cnt0 = 0; done_cnt0 = 0; hs_cnt0 = 0;
        busy_cnt1 = 0; done_cnt1 = 0; hs_cnt1 = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit r, s, a, rdy;
        bit busy, done, romen, vld;
        int fidx;
    } vec_t;

    vec_t tv [15];

    initial begin
        int quiet, viol, rise0, rise1, found;
        bit pulsed;

        rst = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b0;

        tv[0]  = '{1,0,0,1, 0,0,0,0, 0};
        tv[1]  = '{1,0,0,1, 0,0,0,0, 0};
        tv[2]  = '{1,0,0,1, 0,0,0,0, 0};
        tv[3]  = '{0,0,0,1, 0,0,0,0, 0};
        tv[4]  = '{0,0,0,1, 0,0,0,0, 0};
        tv[5]  = '{0,1,0,1, 1,0,1,0, 0};
        tv[6]  = '{0,0,0,0, 1,0,0,0, 0};
        tv[7]  = '{0,0,0,0, 1,0,0,1, 0};
        tv[8]  = '{0,0,0,0, 1,0,0,1, 0};
        tv[9]  = '{0,0,0,1, 1,0,1,0, 0};
        tv[10] = '{0,0,0,1, 1,0,0,0, 0};
        tv[11] = '{0,0,0,1, 1,0,0,1, 1};
        tv[12] = '{0,0,1,1, 0,0,0,0, 1};
        tv[13] = '{0,1,1,0, 0,0,0,0, 1};
        tv[14] = '{0,0,0,0, 0,0,0,0, 1};

        clear_counts();
        for (int n = 0; n < 15; n++) begin
            cyc(tv[n].r, tv[n].s, tv[n].a, tv[n].rdy);
            chk($sformatf("tbl%0d.busy", n), VW'(busy0), VW'(tv[n].busy));
            chk($sformatf("tbl%0d.done", n), VW'(done0), VW'(tv[n].done));
            chk($sformatf("tbl%0d.rom_en", n), VW'(rom_en0), VW'(tv[n].romen));
            chk($sformatf("tbl%0d.w_valid", n), VW'(w_valid0), VW'(tv[n].vld));
            chk($sformatf("tbl%0d.w_filter_idx", n), VW'(fidx0), VW'(tv[n].fidx));
        end

        // Reset then 10 idle cycles: nothing may move.
        for (int n = 0; n < 3; n++) cyc(1, 0, 0, 0);
        quiet = 0;
        for (int n = 0; n < 10; n++) begin
            cyc(0, 0, 0, $urandom_range(0, 1));
            quiet += int'(busy0 | done0 | rom_en0 | w_valid0 | busy1 | done1 | rom_en1 | w_valid1);
        end
        chk("idle_quiet", VW'(quiet), VW'(0));

        // Full run, no back-pressure, both latencies.
        clear_counts();
        rise0 = -1; rise1 = -1;
        cyc(0, 1, 0, 1);
        for (int k = 1; k < 60; k++) begin
            cyc(0, 0, 0, 1);
            if (rise0 < 0 && w_valid0 === 1'b1) rise0 = k;
            if (rise1 < 0 && w_valid1 === 1'b1) rise1 = k;
        end
        chk("run_l1.busy_cycles", VW'(busy_cnt0), VW'(25));
        chk("run_l1.done_pulses", VW'(done_cnt0), VW'(1));
        chk("run_l1.transfers", VW'(hs_cnt0), VW'(8));
        chk("run_l1.first_valid", VW'(rise0), VW'(2));
        chk("run_l3.busy_cycles", VW'(busy_cnt1), VW'(41));
        chk("run_l3.done_pulses", VW'(done_cnt1), VW'(1));
        chk("run_l3.transfers", VW'(hs_cnt1), VW'(8));
        chk("run_l3.first_valid", VW'(rise1), VW'(4));

        // Back-pressure on filter 3.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (w_valid0 === 1'b1 && fidx0 == 3'd3) found = 1;
            else cyc(0, 0, 0, 1);
        end
        chk("bp.reach_filter3", VW'(found), VW'(1));
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, 0, 0);
            if (w_valid0 !== 1'b1 || fidx0 !== 3'd3 || rom_en0 !== 1'b0 ||
                w_data0 !== rom_word(3)) viol++;
        end
        chk("bp.stable", VW'(viol), VW'(0));
        cyc(0, 0, 0, 1);
        chk("bp.next_rom_en", VW'(rom_en0), VW'(1));
        chk("bp.next_rom_addr", VW'(rom_addr0), VW'(4));
        for (int k = 0; k < 60; k++) cyc(0, 0, 0, 1);

        // Abort in HOLD of filter 5 with a same-cycle handshake.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (w_valid0 === 1'b1 && fidx0 == 3'd5) found = 1;
            else cyc(0, 0, 0, 1);
        end
        chk("abort.reach_filter5", VW'(found), VW'(1));
        clear_counts();
        cyc(0, 0, 1, 1);
        chk("abort.busy", VW'(busy0), VW'(0));
        chk("abort.w_valid", VW'(w_valid0), VW'(0));
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1);
        chk("abort.no_done", VW'(done_cnt0), VW'(0));
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("abort.restart_valid", VW'(w_valid0), VW'(1));
        chk("abort.restart_idx", VW'(fidx0), VW'(0));
        cyc(0, 0, 1, 0);

        // Starts during HOLD of filter 2 and during DONE are ignored.
        cyc(1, 0, 0, 0);
        clear_counts();
        cyc(0, 1, 0, 1);
        found = 0; pulsed = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (done0 === 1'b1) found = 1;
            else begin
                bit s;
                s = (w_valid0 === 1'b1) && (fidx0 == 3'd2) && !pulsed;
                if (s) pulsed = 1;
                cyc(0, s, 0, 1);
            end
        end
        chk("ign.done_seen", VW'(found), VW'(1));
        chk("ign.transfers", VW'(hs_cnt0), VW'(8));
        cyc(0, 1, 0, 1);
        chk("ign.start_in_done", VW'(busy0), VW'(0));
        cyc(0, 1, 0, 1);
        chk("ign.start_after_done", VW'(busy0), VW'(1));
        cyc(0, 0, 1, 1);

        // Randomized traffic, including mid-run resets and aborts.
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
